// File: rtl/video_timing_pkg.sv
// Shared raster definitions: default 640x480@60 timing and the coordinate type
// used by the timing generator and the background layer.
package video_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_LINE_LEAD = 2;

endpackage

// File: rtl/video_timing.sv
// Raster timing generator: horizontal/vertical counters plus registered sync,
// position and early-warning strobes. Optional frame counter: VIDEO_TIMING_FRAME_COUNTER_EN.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int LINE_LEAD = DEF_LINE_LEAD
) (
  input  logic   clkPixel,
  input  logic   reset,
  output coord_t hPos,
  output coord_t vPos,
  output logic   visible,
  output logic   hsync,
  output logic   vsync,
  output logic   hsyncStarting,
  output coord_t nextVPos,
  output logic   nextFrameActive,
  output logic   lineStarting,
  output logic   lineEnding,
  output logic   vblankStarting
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t LS_POS   = coord_t'(H_TOTAL - LINE_LEAD);
  localparam coord_t LE_POS   = coord_t'(H_VISIBLE - LINE_LEAD);

  if (LINE_LEAD >= H_FRONT + H_SYNC + H_BACK) begin : gLeadTooLong
    $error("video_timing: LINE_LEAD must be shorter than horizontal blanking");
  end
  if (LINE_LEAD == 0) begin : gLeadZero
    $error("video_timing: LINE_LEAD must be non-zero");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gTooLarge
    $error("video_timing: raster does not fit 10-bit counters");
  end

  coord_t hNext;
  coord_t vNext;
  coord_t nvNext;

  // Next-state counters; every registered output is decoded from these so it
  // lines up with the position it describes.
  always_comb begin
    hNext = hPos + 10'd1;
    vNext = vPos;
    if (hPos == H_LAST) begin
      hNext = 10'd0;
      if (vPos == V_LAST) begin
        vNext = 10'd0;
      end else begin
        vNext = vPos + 10'd1;
      end
    end else begin
      hNext = hPos + 10'd1;
      vNext = vPos;
    end
    nvNext = (vNext == V_LAST) ? 10'd0 : vNext + 10'd1;
  end

  // Counter and decoded-output registers.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      hPos            <= H_LAST;
      vPos            <= V_LAST;
      visible         <= 1'b0;
      hsync           <= 1'b1;
      vsync           <= 1'b1;
      hsyncStarting   <= 1'b0;
      nextVPos        <= 10'd0;
      nextFrameActive <= 1'b1;
      lineStarting    <= 1'b0;
      lineEnding      <= 1'b0;
      vblankStarting  <= 1'b0;
    end else begin
      hPos            <= hNext;
      vPos            <= vNext;
      visible         <= (hNext < H_VIS) && (vNext < V_VIS);
      hsync           <= !((hNext >= HS_START) && (hNext < HS_END));
      vsync           <= !((vNext >= VS_START) && (vNext < VS_END));
      hsyncStarting   <= (hNext == HS_START);
      nextVPos        <= nvNext;
      nextFrameActive <= (nvNext < V_VIS);
      lineStarting    <= (hNext == LS_POS) && (nvNext < V_VIS);
      lineEnding      <= (hNext == LE_POS) && (vNext < V_VIS);
      vblankStarting  <= (hNext == 10'd0) && (vNext == V_VIS);
    end
  end

`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
  // Frame counter steps on the same edge that raises vblankStarting.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      frameCount <= 16'd0;
    end else if ((hNext == 10'd0) && (vNext == V_VIS)) begin
      frameCount <= frameCount + 16'd1;
    end else begin
      frameCount <= frameCount;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing.sv
// Randomized-reset bench for video_timing: a position model derived from the
// raster rules predicts every output each cycle for a default and a small raster.
module tb_video_timing;
  import video_timing_pkg::*;

  int pHV[2] = '{640, 16};
  int pHF[2] = '{16, 4};
  int pHS[2] = '{96, 6};
  int pHB[2] = '{48, 4};
  int pVV[2] = '{480, 12};
  int pVF[2] = '{10, 2};
  int pVS[2] = '{2, 2};
  int pVB[2] = '{33, 3};
  localparam int LL = 2;

  logic clkPixel = 1'b0;
  logic reset = 1'b1;
  always #5 clkPixel = ~clkPixel;

  logic [9:0] hPosA[2], vPosA[2], nextVPosA[2];
  logic visibleA[2], hsyncA[2], vsyncA[2], hsStartA[2], nfaA[2], lsA[2], leA[2], vbA[2];
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
  logic [15:0] fcA[2];
  int fcM[2];
`endif

  int errors = 0;
  int checks = 0;

  video_timing dutDef (
    .clkPixel(clkPixel), .reset(reset), .hPos(hPosA[0]), .vPos(vPosA[0]),
    .visible(visibleA[0]), .hsync(hsyncA[0]), .vsync(vsyncA[0]),
    .hsyncStarting(hsStartA[0]), .nextVPos(nextVPosA[0]), .nextFrameActive(nfaA[0]),
    .lineStarting(lsA[0]), .lineEnding(leA[0]), .vblankStarting(vbA[0])
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    , .frameCount(fcA[0])
`endif
  );

  video_timing #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .LINE_LEAD(LL)
  ) dutSmall (
    .clkPixel(clkPixel), .reset(reset), .hPos(hPosA[1]), .vPos(vPosA[1]),
    .visible(visibleA[1]), .hsync(hsyncA[1]), .vsync(vsyncA[1]),
    .hsyncStarting(hsStartA[1]), .nextVPos(nextVPosA[1]), .nextFrameActive(nfaA[1]),
    .lineStarting(lsA[1]), .lineEnding(leA[1]), .vblankStarting(vbA[1])
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    , .frameCount(fcA[1])
`endif
  );

  function automatic int ht(int i);
    return pHV[i] + pHF[i] + pHS[i] + pHB[i];
  endfunction

  function automatic int vt(int i);
    return pVV[i] + pVF[i] + pVS[i] + pVB[i];
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  // Model raster position: reset parks at the last pixel of the last line.
  int mh[2], mv[2];
  always @(posedge clkPixel or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mh[i] <= ht(i) - 1;
        mv[i] <= vt(i) - 1;
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
        fcM[i] <= 0;
`endif
      end else if (mh[i] == ht(i) - 1) begin
        mh[i] <= 0;
        mv[i] <= (mv[i] == vt(i) - 1) ? 0 : mv[i] + 1;
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
        if (mv[i] == pVV[i] - 1) fcM[i] <= (fcM[i] + 1) % 65536;
`endif
      end else begin
        mh[i] <= mh[i] + 1;
      end
    end
  end

  int lsCnt[2], leCnt[2], hsCnt[2], vbCnt[2], hsLow[2], hsLine[2];
  bit winValid[2], lineValid[2];

  // Per-cycle comparison against the raster rules, plus per-line and per-frame tallies.
  always @(negedge clkPixel) begin
    for (int i = 0; i < 2; i++) begin
      int h, v, nv;
      h = mh[i];
      v = mv[i];
      nv = (v + 1) % vt(i);
      chk("hPos", i, int'(hPosA[i]), h);
      chk("vPos", i, int'(vPosA[i]), v);
      chk("visible", i, int'(visibleA[i]), int'(h < pHV[i] && v < pVV[i]));
      chk("hsync", i, int'(hsyncA[i]),
          int'(!(h >= pHV[i] + pHF[i] && h < pHV[i] + pHF[i] + pHS[i])));
      chk("vsync", i, int'(vsyncA[i]),
          int'(!(v >= pVV[i] + pVF[i] && v < pVV[i] + pVF[i] + pVS[i])));
      chk("hsyncStarting", i, int'(hsStartA[i]), int'(!reset && h == pHV[i] + pHF[i]));
      chk("nextVPos", i, int'(nextVPosA[i]), nv);
      chk("nextFrameActive", i, int'(nfaA[i]), int'(nv < pVV[i]));
      chk("lineStarting", i, int'(lsA[i]), int'(!reset && h == ht(i) - LL && nv < pVV[i]));
      chk("lineEnding", i, int'(leA[i]), int'(!reset && h == pHV[i] - LL && v < pVV[i]));
      chk("vblankStarting", i, int'(vbA[i]), int'(!reset && h == 0 && v == pVV[i]));
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
      chk("frameCount", i, int'(fcA[i]), fcM[i]);
`endif
      if (reset) begin
        winValid[i] = 1'b0;
        lineValid[i] = 1'b0;
      end else begin
        if (h == 0) begin
          if (lineValid[i]) begin
            chk("hsyncLowPerLine", i, hsLow[i], pHS[i]);
            chk("hsyncStartPerLine", i, hsLine[i], 1);
          end
          lineValid[i] = 1'b1;
          hsLow[i] = 0;
          hsLine[i] = 0;
        end
        if (h == 0 && v == 0) begin
          if (winValid[i]) begin
            chk("lineStartingPerFrame", i, lsCnt[i], pVV[i]);
            chk("lineEndingPerFrame", i, leCnt[i], pVV[i]);
            chk("hsyncStartingPerFrame", i, hsCnt[i], vt(i));
            chk("vblankPerFrame", i, vbCnt[i], 1);
          end
          winValid[i] = 1'b1;
          lsCnt[i] = 0; leCnt[i] = 0; hsCnt[i] = 0; vbCnt[i] = 0;
        end
        lsCnt[i] += int'(lsA[i]);
        leCnt[i] += int'(leA[i]);
        hsCnt[i] += int'(hsStartA[i]);
        vbCnt[i] += int'(vbA[i]);
        hsLow[i] += int'(!hsyncA[i]);
        hsLine[i] += int'(hsStartA[i]);
      end
    end
  end

  bit found;

  initial begin
    // Reset state, hand-computed.
    repeat (3) @(posedge clkPixel);
    #1;
    chk("litResetH", 0, int'(hPosA[0]), 799);
    chk("litResetV", 0, int'(vPosA[0]), 524);
    chk("litResetNextV", 0, int'(nextVPosA[0]), 0);
    chk("litResetNfa", 0, int'(nfaA[0]), 1);
    chk("litResetVis", 0, int'(visibleA[0]), 0);
    chk("litResetH", 1, int'(hPosA[1]), 29);
    chk("litResetV", 1, int'(vPosA[1]), 18);
    #1 reset = 1'b0;
    @(posedge clkPixel); #1;
    chk("litFirstH", 0, int'(hPosA[0]), 0);
    chk("litFirstV", 0, int'(vPosA[0]), 0);
    chk("litFirstVis", 0, int'(visibleA[0]), 1);
    chk("litFirstNextV", 0, int'(nextVPosA[0]), 1);
    repeat (656) @(posedge clkPixel); #1;
    chk("litHsStartAt656", 0, int'(hsStartA[0]), 1);
    chk("litHsyncLowAt656", 0, int'(hsyncA[0]), 0);
    repeat (96) @(posedge clkPixel); #1;
    chk("litHsyncHighAt752", 0, int'(hsyncA[0]), 1);
    repeat (1800) @(posedge clkPixel);

    // Mid-frame asynchronous reset on the small raster at (20,8).
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(posedge clkPixel); #1;
      found = (hPosA[1] == 10'd20) && (vPosA[1] == 10'd8);
    end
    chk("waitMidFrame", 1, int'(found), 1);
    reset = 1'b1;
    #1;
    chk("litAsyncH", 1, int'(hPosA[1]), 29);
    chk("litAsyncV", 1, int'(vPosA[1]), 18);
    chk("litAsyncVis", 1, int'(visibleA[1]), 0);
    chk("litAsyncH", 0, int'(hPosA[0]), 799);
    repeat (3) @(posedge clkPixel);
    #2 reset = 1'b0;
    @(posedge clkPixel); #1;
    chk("litResumeH", 1, int'(hPosA[1]), 0);
    chk("litResumeV", 1, int'(vPosA[1]), 0);

    // Random run lengths interleaved with random reset pulses.
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(900, 50)) @(posedge clkPixel);
      #2 reset = 1'b1;
      repeat ($urandom_range(3, 1)) @(posedge clkPixel);
      #2 reset = 1'b0;
    end
    repeat (1800) @(posedge clkPixel);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
